// File: rtl/regfile_wb_arb.sv
// Two-port writeback arbiter that drives a registered register-file write port and keeps a pending-write scoreboard.
// Defining REGFILE_WB_ARB_RR_EN selects round-robin contention; otherwise port 1 has priority and port 0 has a starvation limit.
module regfile_wb_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        wbValid0,
  input  logic [4:0]  wbAddr0,
  input  logic [31:0] wbData0,
  output logic        wbReady0,
  input  logic        wbValid1,
  input  logic [4:0]  wbAddr1,
  input  logic [31:0] wbData1,
  output logic        wbReady1,
  output logic        regWrite,
  output logic [4:0]  regAddrWrite,
  output logic [31:0] regWriteData,
  input  logic        rsvValid,
  input  logic [4:0]  rsvAddr,
  input  logic [4:0]  chkAddrA,
  input  logic [4:0]  chkAddrB,
  output logic        hazardA,
  output logic        hazardB,
  output logic [31:0] pendingMask
);

  logic grant0, grant1, contend;
  assign contend = wbValid0 && wbValid1;

`ifdef REGFILE_WB_ARB_RR_EN
  // rr_ptr_q = 1 means port 1 wins the next contended cycle
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (rstN) begin
      if (contend) begin
        grant1   = rr_ptr_q;
        grant0   = !rr_ptr_q;
        rr_ptr_d = !rr_ptr_q;
      end else begin
        grant0 = wbValid0;
        grant1 = wbValid1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rr_ptr_q <= 1'b1;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    starve_d = starve_q;
    if (rstN) begin
      if (contend) begin
        grant0 = (starve_q == LIMIT);
        grant1 = (starve_q != LIMIT);
      end else begin
        grant0 = wbValid0;
        grant1 = wbValid1;
      end
      if (wbValid0 && grant0)          starve_d = 4'd0;
      else if (wbValid0 && starve_q != LIMIT) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`endif

  assign wbReady0 = grant0;
  assign wbReady1 = grant1;

  logic        reg_write_q, reg_write_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_data_q, reg_data_d;
  logic [31:0] pending_q, pending_d;
  logic        xfer;
  logic [4:0]  xfer_addr;
  logic [31:0] xfer_data;

  assign xfer      = (wbValid0 && grant0) || (wbValid1 && grant1);
  assign xfer_addr = grant1 ? wbAddr1 : wbAddr0;
  assign xfer_data = grant1 ? wbData1 : wbData0;

  // Writes to r0 are accepted but dropped; the last real write stays on the port.
  always_comb begin
    reg_write_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    if (xfer && xfer_addr != 5'd0) begin
      reg_write_d = 1'b1;
      reg_addr_d  = xfer_addr;
      reg_data_d  = xfer_data;
    end
  end

  // Clear is applied before set so a same-cycle reservation wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_q) pending_d[reg_addr_q] = 1'b0;
    if (rsvValid && rsvAddr != 5'd0) pending_d[rsvAddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      reg_write_q <= 1'b0;
      reg_addr_q  <= 5'd0;
      reg_data_q  <= 32'd0;
      pending_q   <= 32'd0;
    end else begin
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      pending_q   <= pending_d;
    end
  end

  assign regWrite     = reg_write_q;
  assign regAddrWrite = reg_addr_q;
  assign regWriteData = reg_data_q;
  assign pendingMask  = pending_q;
  assign hazardA      = pending_q[chkAddrA];
  assign hazardB      = pending_q[chkAddrB];

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed self-checking bench for regfile_wb_arb; inputs change on the falling edge, checks run 1ns later.
module tb_regfile_wb_arb;
  logic        clk;
  logic        rstN;
  logic        wbValid0, wbValid1, wbReady0, wbReady1;
  logic [4:0]  wbAddr0, wbAddr1;
  logic [31:0] wbData0, wbData1;
  logic        regWrite;
  logic [4:0]  regAddrWrite;
  logic [31:0] regWriteData;
  logic        rsvValid;
  logic [4:0]  rsvAddr, chkAddrA, chkAddrB;
  logic        hazardA, hazardB;
  logic [31:0] pendingMask;

  int errors = 0;
  int checks = 0;

  regfile_wb_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rstN(rstN),
    .wbValid0(wbValid0), .wbAddr0(wbAddr0), .wbData0(wbData0), .wbReady0(wbReady0),
    .wbValid1(wbValid1), .wbAddr1(wbAddr1), .wbData1(wbData1), .wbReady1(wbReady1),
    .regWrite(regWrite), .regAddrWrite(regAddrWrite), .regWriteData(regWriteData),
    .rsvValid(rsvValid), .rsvAddr(rsvAddr),
    .chkAddrA(chkAddrA), .chkAddrB(chkAddrB), .hazardA(hazardA), .hazardB(hazardB),
    .pendingMask(pendingMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_grant;
    rstN = 1'b0;
    wbValid0 = 1'b1; wbAddr0 = 5'd5; wbData0 = 32'hDEADBEEF;
    wbValid1 = 1'b0; wbAddr1 = 5'd0; wbData1 = 32'd0;
    rsvValid = 1'b0; rsvAddr = 5'd0; chkAddrA = 5'd0; chkAddrB = 5'd0;

    #12;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_addr", regAddrWrite, 0);
    chk("rst_data", regWriteData, 0);
    chk("rst_mask", pendingMask, 0);
    chk("rst_ready0", wbReady0, 0);

    // Port 0 alone: addr 5, 0xDEADBEEF
    @(negedge clk); rstN = 1'b1;
    #1;
    chk("p0_ready0", wbReady0, 1);
    chk("p0_ready1", wbReady1, 0);
    @(negedge clk); wbValid0 = 1'b0;
    #1;
    chk("p0_regWrite", regWrite, 1);
    chk("p0_addr", regAddrWrite, 5);
    chk("p0_data", regWriteData, 32'hDEADBEEF);
    $display("txn p0 write addr=%0d data=%08h", regAddrWrite, regWriteData);
    @(negedge clk); #1;
    chk("p0_idle_regWrite", regWrite, 0);
    chk("p0_hold_addr", regAddrWrite, 5);

    // Continuous contention
    wbValid0 = 1'b1; wbAddr0 = 5'd2; wbData0 = 32'h22;
    wbValid1 = 1'b1; wbAddr1 = 5'd3; wbData1 = 32'h33;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef REGFILE_WB_ARB_RR_EN
      exp_grant = (i % 2 == 1) ? 2'b01 : 2'b10;
`else
      exp_grant = (i % 5 == 4) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("contend_grant%0d", i), {wbReady1, wbReady0}, exp_grant);
      $display("txn contend cycle %0d grant {r1,r0}=%b", i, {wbReady1, wbReady0});
      @(negedge clk);
    end
    wbValid0 = 1'b0; wbValid1 = 1'b0;

    // Port 1 write to r0
    wbValid1 = 1'b1; wbAddr1 = 5'd0; wbData1 = 32'h1234;
    #1;
    chk("r0_ready1", wbReady1, 1);
    chk("r0_ready0", wbReady0, 0);
    @(negedge clk); wbValid1 = 1'b0;
    #1;
    chk("r0_regWrite", regWrite, 0);
    chk("r0_mask", pendingMask, 0);
    $display("txn p1 write addr=0 dropped");

    // Reserve r7 then write it
    rsvValid = 1'b1; rsvAddr = 5'd7; chkAddrA = 5'd7; chkAddrB = 5'd0;
    @(negedge clk); rsvValid = 1'b0;
    wbValid0 = 1'b1; wbAddr0 = 5'd7; wbData0 = 32'h77;
    #1;
    chk("r7_mask", pendingMask, 32'h80);
    chk("r7_hazA_pend", hazardA, 1);
    chk("r7_hazB_r0", hazardB, 0);
    chk("r7_ready0", wbReady0, 1);
    @(negedge clk); wbValid0 = 1'b0;
    #1;
    chk("r7_regWrite", regWrite, 1);
    chk("r7_addr", regAddrWrite, 7);
    chk("r7_hazA_wr", hazardA, 1);
    @(negedge clk); #1;
    chk("r7_hazA_done", hazardA, 0);
    chk("r7_mask_clr", pendingMask, 0);
    $display("txn r7 reserve/write/clear");

    // Reservation of r0 is ignored
    rsvValid = 1'b1; rsvAddr = 5'd0;
    @(negedge clk); rsvValid = 1'b0;
    #1;
    chk("rsv_r0_mask", pendingMask, 0);

    // Set and clear of r9 in the same cycle leaves it set
    rsvValid = 1'b1; rsvAddr = 5'd9;
    @(negedge clk); rsvValid = 1'b0;
    wbValid1 = 1'b1; wbAddr1 = 5'd9; wbData1 = 32'h99;
    #1;
    chk("r9_mask_set", pendingMask, 32'h200);
    @(negedge clk); wbValid1 = 1'b0;
    rsvValid = 1'b1; rsvAddr = 5'd9;
    #1;
    chk("r9_regWrite", regWrite, 1);
    chk("r9_addr", regAddrWrite, 9);
    @(negedge clk); rsvValid = 1'b0;
    #1;
    chk("r9_mask_kept", pendingMask, 32'h200);
    chk("r9_idle", regWrite, 0);
    wbValid1 = 1'b1;
    @(negedge clk); wbValid1 = 1'b0;
    @(negedge clk); #1;
    chk("r9_mask_clr", pendingMask, 0);
    $display("txn r9 set/clear collision");

    // Asynchronous reset mid-traffic
    rsvValid = 1'b1; rsvAddr = 5'd7;
    @(negedge clk); rsvValid = 1'b0;
    wbValid0 = 1'b1; wbAddr0 = 5'd4; wbData0 = 32'h44;
    wbValid1 = 1'b1; wbAddr1 = 5'd5; wbData1 = 32'h55;
    #1;
    chk("prerst_mask", pendingMask, 32'h80);
    chk("prerst_ready1", wbReady1, 1);
    @(negedge clk); #1;
    chk("prerst_regWrite", regWrite, 1);
    #1 rstN = 1'b0;
    #1;
    chk("arst_regWrite", regWrite, 0);
    chk("arst_addr", regAddrWrite, 0);
    chk("arst_data", regWriteData, 0);
    chk("arst_mask", pendingMask, 0);
    chk("arst_ready", {wbReady1, wbReady0}, 0);
    @(negedge clk); rstN = 1'b1;
    #1;
    chk("postrst_grant", {wbReady1, wbReady0}, 2'b10);
    @(negedge clk); #1;
    chk("postrst_regWrite", regWrite, 1);
    chk("postrst_addr", regAddrWrite, 5);
    chk("postrst_data", regWriteData, 32'h55);
    $display("txn reset recovery write addr=%0d data=%08h", regAddrWrite, regWriteData);
    wbValid0 = 1'b0; wbValid1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
